// File: rtl/drawing_pkg.sv
// Package: drawing_pkg
// Shared types and default geometry for the rectangle fill engine.
// The optional checkerboard colouring is selected by the RECT_CHECKER_EN macro
// in rect_fill_drawer; nothing in this package depends on it.
package drawing_pkg;

    // Default screen geometry for the 160x120 VGA frame buffer path.
    localparam int DEF_SCR_W = 160;
    localparam int DEF_SCR_H = 120;
    localparam int DEF_CW    = 3;
    localparam int DEF_XW    = $clog2(DEF_SCR_W);
    localparam int DEF_YW    = $clog2(DEF_SCR_H);

    // Job sequencing: wait for start, sweep the rectangle, pulse done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // One pixel as seen on the adapter write port at default geometry.
    typedef struct packed {
        logic [DEF_XW-1:0] x;
        logic [DEF_YW-1:0] y;
        logic [DEF_CW-1:0] color;
    } pixel_t;

endpackage

// File: rtl/draw_axis_counter.sv
// Module: draw_axis_counter
// Loadable up-counter for one raster axis. A load captures base and limit and
// starts the count at base; each enable steps by one, and a step taken while
// sitting on the limit returns to base and raises wrap for that cycle.
module draw_axis_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_base,
    input  logic [W-1:0] load_limit,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] base_q;
    logic [W-1:0] limit_q;
    logic [W-1:0] value_q;
    logic         at_limit;

    assign at_limit = (value_q == limit_q);

    // Capture the axis range on load, otherwise step or wrap on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state is written with <= so every flop samples pre-edge values.
            base_q  <= '0;
            limit_q <= '0;
            value_q <= '0;
        end else if (load) begin
            base_q  <= load_base;
            limit_q <= load_limit;
            value_q <= load_base;
        end else if (en) begin
            value_q <= at_limit ? base_q : value_q + W'(1);
        end
    end

    // A step from the limit is the wrap event the next axis counts on.
    always_comb begin
        wrap  = en && at_limit;
        value = value_q;
    end

endmodule

// File: rtl/rect_fill_drawer.sv
// Module: rect_fill_drawer
// Pixel-sweep engine for the VGA frame buffer path. A start in IDLE captures a
// rectangle (or the whole screen in clear mode), clips it to the screen and
// emits one pixel per accepted valid/ready beat in raster order, then pulses
// done. Optional feature macro: RECT_CHECKER_EN (checkerboard of color_in and
// bg_color); without it every pixel uses color_in and bg_color is ignored.
module rect_fill_drawer
    import drawing_pkg::*;
#(
    parameter int SCR_W = DEF_SCR_W,
    parameter int SCR_H = DEF_SCR_H,
    parameter int CW    = DEF_CW,
    parameter int XW    = $clog2(SCR_W),
    parameter int YW    = $clog2(SCR_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    input  logic [CW-1:0] color_in,
    input  logic [CW-1:0] bg_color,
    output logic          busy,
    output logic          plot,
    input  logic          plot_ready,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] color,
    output logic          done
);

    // Bound sums carry one bit beyond the w/h port width so that x0+w and
    // y0+h stay exact even for the largest width/height values.
    localparam int XS = XW + 2;
    localparam int YS = YW + 2;
    localparam logic [XS-1:0] SCR_W_X = XS'(SCR_W);
    localparam logic [YS-1:0] SCR_H_Y = YS'(SCR_H);
    localparam logic [XW-1:0] X_LAST  = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(SCR_H - 1);

    state_t        state_q;
    state_t        state_d;

    logic [XS-1:0] x_sum;
    logic [YS-1:0] y_sum;
    logic [XS-1:0] x_end;
    logic [YS-1:0] y_end;
    logic [XW-1:0] x_base_n;
    logic [XW-1:0] x_lim_n;
    logic [YW-1:0] y_base_n;
    logic [YW-1:0] y_lim_n;
    logic          empty_job;

    logic          accept;
    logic          load;
    logic          beat;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          x_wrap;
    logic          y_wrap;

    logic [CW-1:0] fg_q;

    // Clip the requested rectangle to the screen and flag jobs with no pixels.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        x_sum = XS'(x0) + XS'(w);
        y_sum = YS'(y0) + YS'(h);
        x_end = (x_sum > SCR_W_X) ? SCR_W_X : x_sum;
        y_end = (y_sum > SCR_H_Y) ? SCR_H_Y : y_sum;
        if (mode) begin
            x_base_n  = '0;
            x_lim_n   = X_LAST;
            y_base_n  = '0;
            y_lim_n   = Y_LAST;
            empty_job = 1'b0;
        end else begin
            x_base_n  = x0;
            x_lim_n   = XW'(x_end - XS'(1));
            y_base_n  = y0;
            y_lim_n   = YW'(y_end - YS'(1));
            empty_job = (w == '0) || (h == '0) ||
                        (XS'(x0) >= SCR_W_X) || (YS'(y0) >= SCR_H_Y);
        end
    end

    // Handshake qualifiers: jobs are taken only from IDLE; a beat is a
    // pixel the adapter actually accepted.
    always_comb begin
        accept = (state_q == IDLE) && start;
        load   = accept && !empty_job;
        beat   = plot && plot_ready;
    end

    // x sweeps on every accepted beat; y steps each time x wraps.
    draw_axis_counter #(.W(XW)) u_x_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_base  (x_base_n),
        .load_limit (x_lim_n),
        .en         (beat),
        .value      (x_cnt),
        .wrap       (x_wrap)
    );

    draw_axis_counter #(.W(YW)) u_y_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_base  (y_base_n),
        .load_limit (y_lim_n),
        .en         (x_wrap),
        .value      (y_cnt),
        .wrap       (y_wrap)
    );

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: y wrapping means the beat on the last pixel just completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = empty_job ? DONE : DRAW;
            DRAW:    if (y_wrap) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        plot = (state_q == DRAW);
        busy = (state_q == DRAW) || (state_q == DONE);
        done = (state_q == DONE);
        x    = x_cnt;
        y    = y_cnt;
    end

    // Fill colour is frozen at job start so later input changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fg_q <= '0;
        end else if (accept) begin
            fg_q <= color_in;
        end
    end

`ifdef RECT_CHECKER_EN
    logic [CW-1:0] bg_q;

    // Second checker colour, frozen at job start alongside the fill colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bg_q <= '0;
        end else if (accept) begin
            bg_q <= bg_color;
        end
    end

    // Odd (x+y) parity squares take the background colour.
    always_comb begin
        color = (x_cnt[0] ^ y_cnt[0]) ? bg_q : fg_q;
    end
`else
    logic unused_bg;

    // Solid fill; bg_color stays on the port for pin compatibility only.
    always_comb begin
        color     = fg_q;
        unused_bg = ^bg_color;
    end
`endif

endmodule

// File: tb/tb_rect_fill_drawer.sv
// Testbench: tb_rect_fill_drawer
// Table-driven and randomized jobs checked against a raster model built from
// nested loops over the clipped rectangle, plus a hand-written mid-job reset.
`timescale 1ns/1ps
module tb_rect_fill_drawer;
    import drawing_pkg::*;

    localparam int SW = DEF_SCR_W;
    localparam int SH = DEF_SCR_H;
    localparam int XW = DEF_XW;
    localparam int YW = DEF_YW;
    localparam int CW = DEF_CW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW:0]   w;
    logic [YW:0]   h;
    logic [CW-1:0] color_in;
    logic [CW-1:0] bg_color;
    logic          busy;
    logic          plot;
    logic          plot_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] color;
    logic          done;

    rect_fill_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .color_in   (color_in),
        .bg_color   (bg_color),
        .busy       (busy),
        .plot       (plot),
        .plot_ready (plot_ready),
        .x          (x),
        .y          (y),
        .color      (color),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One job: inputs plus hand-derived expectations (-1 = use model only).
    typedef struct {
        logic mode;
        int   x0;
        int   y0;
        int   w;
        int   h;
        int   fg;
        int   bg;
        int   rmode;     // 0: ready high, 1: 1,0,0,1 repeating, 2: random
        bit   noise;     // scramble inputs and pulse start while busy
        int   exp_beats;
        int   exp_done;  // cycle of done, start cycle counted as 1
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    pixel_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected pixel stream: every screen pixel inside the rectangle, raster order.
    function automatic void build_model(input vec_t v);
        int xs, xe, ys, ye;
        pixel_t p;
        exp_q.delete();
        if (v.mode) begin
            xs = 0; xe = SW; ys = 0; ye = SH;
        end else begin
            xs = v.x0;
            ys = v.y0;
            xe = (v.x0 + v.w < SW) ? v.x0 + v.w : SW;
            ye = (v.y0 + v.h < SH) ? v.y0 + v.h : SH;
        end
        for (int yy = ys; yy < ye; yy++) begin
            for (int xx = xs; xx < xe; xx++) begin
                p.x = xx[XW-1:0];
                p.y = yy[YW-1:0];
`ifdef RECT_CHECKER_EN
                p.color = (((xx ^ yy) & 1) != 0) ? v.bg[CW-1:0] : v.fg[CW-1:0];
`else
                p.color = v.fg[CW-1:0];
`endif
                exp_q.push_back(p);
            end
        end
    endfunction

    function automatic logic ready_val(input int rmode, input int k);
        case (rmode)
            1:       return (k % 4 == 0) || (k % 4 == 3);
            2:       return ($urandom_range(0, 3) != 0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic scramble_inputs();
        mode     = 1'($urandom_range(0, 1));
        x0       = XW'($urandom);
        y0       = YW'($urandom);
        w        = (XW + 1)'($urandom);
        h        = (YW + 1)'($urandom);
        color_in = CW'($urandom);
        bg_color = CW'($urandom);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input string name);
        int     cyc, beats, stalls, pix_bad, busy_bad, k, bound, exp_n, done_cyc, idle_bad;
        bit     got_done;
        logic   r;
        pixel_t got;
        build_model(v);
        exp_n    = exp_q.size();
        beats    = 0;
        stalls   = 0;
        pix_bad  = 0;
        busy_bad = 0;
        k        = 0;
        done_cyc = 0;
        idle_bad = 0;
        got_done = 1'b0;
        bound    = 4 * exp_n + 20;

        @(negedge clk);
        mode       = v.mode;
        x0         = XW'(v.x0);
        y0         = YW'(v.y0);
        w          = (XW + 1)'(v.w);
        h          = (YW + 1)'(v.h);
        color_in   = CW'(v.fg);
        bg_color   = CW'(v.bg);
        plot_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 2;
        while (cyc <= bound) begin
            if (busy !== 1'b1) busy_bad++;
            if (plot === 1'b1) begin
                got = {x, y, color};
                if (exp_q.size() == 0) begin
                    if (pix_bad == 0)
                        $display("  %s: extra pixel (%0d,%0d,%0d)", name, x, y, color);
                    pix_bad++;
                end else if (got !== exp_q[0]) begin
                    if (pix_bad == 0)
                        $display("  %s: beat %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, beats,
                                 x, y, color, exp_q[0].x, exp_q[0].y, exp_q[0].color);
                    pix_bad++;
                end
                r = ready_val(v.rmode, k);
                k++;
                plot_ready = r;
                if (r) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beats++;
                end else begin
                    stalls++;
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (v.noise) begin
                scramble_inputs();
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end

        if (!got_done) begin
            check({name, " done seen"}, 32'(got_done), 32'd1);
            pulse_reset();
            return;
        end

        // A start in the DONE cycle must be dropped.
        if (v.noise) begin
            scramble_inputs();
            start = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0) idle_bad++;
        end

        check({name, " pixels wrong"}, 32'(pix_bad), 32'd0);
        check({name, " beats"}, 32'(beats), 32'(exp_n));
        check({name, " busy gaps"}, 32'(busy_bad), 32'd0);
        check({name, " done cycle"}, 32'(done_cyc), 32'(exp_n + 2 + stalls));
        check({name, " idle after done"}, 32'(idle_bad), 32'd0);
        if (v.exp_beats >= 0) begin
            check({name, " table beats"}, 32'(beats), 32'(v.exp_beats));
            check({name, " table done"}, 32'(done_cyc), 32'(v.exp_done));
        end
    endtask

    vec_t vecs[9];
    vec_t rv;
    int   seen;

    initial begin
        //            mode   x0   y0   w  h  fg bg r  n  beats  done
        vecs[0] = '{1'b0,  10,  20,  3, 2, 3, 4, 0, 0, 6,     8};
        vecs[1] = '{1'b0, 158, 119,  4, 3, 5, 2, 0, 0, 2,     4};
        vecs[2] = '{1'b0,   5,   5,  0, 4, 1, 6, 0, 0, 0,     2};
        vecs[3] = '{1'b0, 160,   5,  5, 5, 1, 6, 0, 0, 0,     2};
        vecs[4] = '{1'b0,  10,  20,  3, 2, 6, 1, 1, 0, 6,     14};
        vecs[5] = '{1'b0,  30,  40,  7, 0, 2, 5, 0, 0, 0,     2};
        vecs[6] = '{1'b0,  30, 120,  7, 3, 2, 5, 0, 0, 0,     2};
        vecs[7] = '{1'b1, 200, 100, 50, 9, 7, 2, 0, 1, 19200, 19202};
        vecs[8] = '{1'b0, 159, 119,  1, 1, 4, 3, 0, 1, 1,     3};

        reset      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        x0         = '0;
        y0         = '0;
        w          = '0;
        h          = '0;
        color_in   = '0;
        bg_color   = '0;
        plot_ready = 1'b1;

        #3;
        check("reset plot", 32'(plot), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset x", 32'(x), 32'd0);
        check("reset y", 32'(y), 32'd0);
        check("reset color", 32'(color), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of an 8x8 job after five beats.
        @(negedge clk);
        mode = 1'b0; x0 = 8'd20; y0 = 7'd30; w = 9'd8; h = 8'd8;
        color_in = 3'd5; bg_color = 3'd2; plot_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("midjob x", 32'(x), 32'd25);
        check("midjob y", 32'(y), 32'd30);
        check("midjob plot", 32'(plot), 32'd1);
        reset = 1'b0;
        #1;
        check("abort plot", 32'(plot), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort x", 32'(x), 32'd0);
        check("abort y", 32'(y), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("abort quiet", 32'(seen), 32'd0);

        for (int i = 0; i < 9; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            rv.mode  = ($urandom_range(0, 9) == 0);
            rv.x0    = $urandom_range(0, 165);
            rv.y0    = $urandom_range(0, 125);
            rv.w     = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 24);
            rv.h     = $urandom_range(0, 16);
            rv.fg    = $urandom_range(0, 7);
            rv.bg    = $urandom_range(0, 7);
            rv.rmode = 2;
            rv.noise = 1'($urandom_range(0, 1));
            rv.exp_beats = -1;
            rv.exp_done  = -1;
            if (rv.mode) rv.noise = 1'b0;
            run_job(rv, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
